// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame transmitter: FSM encoding,
// lane geometry and byte-enable helpers.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } tx_state_e;

  localparam int          LANES     = 4;
  localparam int          LANE_W    = $clog2(LANES);
  localparam logic [15:0] FULL_KEEP = 16'hFFFF;

  // Byte enables for a beat whose highest filled lane is last_lane.
  function automatic logic [15:0] lane_keep(input logic [LANE_W-1:0] last_lane);
    logic [15:0] keep_v;
    case (last_lane)
      2'd0:    keep_v = 16'h000F;
      2'd1:    keep_v = 16'h00FF;
      2'd2:    keep_v = 16'h0FFF;
      default: keep_v = FULL_KEEP;
    endcase
    return keep_v;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry output register for the packed beat stream: loads a new beat,
// holds it while the consumer stalls, and clears valid after the handshake.
module axis_out_reg #(
  parameter int W = 145
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Beat storage: a load wins over the handshake so back-to-back beats have no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/axis_frame_tx.sv
// Packs a frame of 32-bit words into 128-bit AXI-Stream beats for a DMA
// write channel, with a partial, zero-filled last beat and a done pulse.
module axis_frame_tx
  import axis_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  input  logic [31:0]      s_word_tdata,
  input  logic             s_word_tvalid,
  output logic             s_word_tready,
  output logic [127:0]     m_axis_s2mm_tdata,
  output logic [15:0]      m_axis_s2mm_tkeep,
  output logic             m_axis_s2mm_tvalid,
  output logic             m_axis_s2mm_tlast,
  input  logic             m_axis_s2mm_tready
);

  localparam logic [LEN_W-1:0]  ZERO_WORDS = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  ONE_WORD   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LANE_W-1:0] LAST_LANE  = 2'd3;

  tx_state_e         state_r;
  logic [LEN_W-1:0]  words_left_r;
  logic [LANE_W-1:0] lane_r;
  logic [127:0]      acc_r;
  logic              busy_r;
  logic              done_r;

  logic              last_word_s;
  logic              completes_s;
  logic              out_free_s;
  logic              word_ready_s;
  logic              word_xfer_s;
  logic              beat_load_s;
  logic              tlast_hs_s;
  logic [127:0]      beat_data_s;
  logic [15:0]       beat_keep_s;
  logic              out_valid_s;
  logic [144:0]      out_bus_s;

  // Accept/complete decisions and the beat image as it would look with the current word added.
  always_comb begin
    last_word_s = (words_left_r == ONE_WORD);
    completes_s = (lane_r == LAST_LANE) || last_word_s;
    out_free_s  = !out_valid_s || m_axis_s2mm_tready;
    if (state_r == PACK) begin
      word_ready_s = !completes_s || out_free_s;
    end else begin
      word_ready_s = 1'b0;
    end
    word_xfer_s = s_word_tvalid && word_ready_s;
    beat_load_s = word_xfer_s && completes_s;
    tlast_hs_s  = out_valid_s && m_axis_s2mm_tready && out_bus_s[0];
    beat_data_s = acc_r;
    case (lane_r)
      2'd0:    beat_data_s[31:0]   = s_word_tdata;
      2'd1:    beat_data_s[63:32]  = s_word_tdata;
      2'd2:    beat_data_s[95:64]  = s_word_tdata;
      default: beat_data_s[127:96] = s_word_tdata;
    endcase
    beat_keep_s = lane_keep(lane_r);
  end

  // Frame sequencer: start acceptance, word counting, lane packing and completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      words_left_r <= ZERO_WORDS;
      lane_r       <= {LANE_W{1'b0}};
      acc_r        <= 128'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_start && (cfg_len != ZERO_WORDS)) begin
            state_r      <= PACK;
            words_left_r <= cfg_len;
            lane_r       <= {LANE_W{1'b0}};
            acc_r        <= 128'd0;
            busy_r       <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        PACK: begin
          if (word_xfer_s) begin
            if (words_left_r != ZERO_WORDS) begin
              words_left_r <= words_left_r - ONE_WORD;
            end else begin
              words_left_r <= ZERO_WORDS;
            end
            // Accumulator is cleared per beat so unfilled lanes of a short beat read as zero.
            if (completes_s) begin
              lane_r <= {LANE_W{1'b0}};
              acc_r  <= 128'd0;
            end else begin
              lane_r <= lane_r + 2'd1;
              acc_r  <= beat_data_s;
            end
            if (last_word_s) begin
              state_r <= DRAIN;
            end else begin
              state_r <= PACK;
            end
          end else begin
            state_r <= PACK;
          end
        end
        DRAIN: begin
          if (tlast_hs_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  axis_out_reg #(
    .W(145)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (beat_load_s),
    .load_data ({beat_data_s, beat_keep_s, last_word_s}),
    .ready     (m_axis_s2mm_tready),
    .valid     (out_valid_s),
    .data      (out_bus_s)
  );

  assign busy               = busy_r;
  assign done               = done_r;
  assign s_word_tready      = word_ready_s;
  assign m_axis_s2mm_tvalid = out_valid_s;
  assign m_axis_s2mm_tdata  = out_bus_s[144:17];
  assign m_axis_s2mm_tkeep  = out_bus_s[16:1];
  assign m_axis_s2mm_tlast  = out_bus_s[0];

endmodule
